register_bank: RTL and testbench

MIPS register file at the receiving end of the write-back stage: 32 × B-bit general registers, one write port driven by write-back (selected data + RegWrite), two combinational read ports for decode with same-cycle write bypass. Also holds a pending-write scoreboard that raises `stall` while a decode operand waits on an outstanding load. Provides a handshaked debug read port for the host-side register dump.

---
 rtl/regbank_pkg.sv | 28 ++
 rtl/regbank_scoreboard.sv | 59 +++++
 rtl/register_bank.sv | 129 ++++++++++++
 tb/tb_register_bank.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// ----------------------------------------------------------------------------
// regbank_pkg
// Shared definitions for the MIPS register bank:
//   B         - data width of one general register
//   D         - register address width (NUM_REGS = 2^D)
//   NUM_REGS  - number of general registers
//   ZERO_REG  - hard-wired zero register index
//   dbg_state_t - encoding of the debug read-port handshake FSM
//   is_zero() - true when an address selects the hard-wired zero register
// ----------------------------------------------------------------------------
package regbank_pkg;

    localparam int B        = 32;
    localparam int D        = 5;
    localparam int NUM_REGS = 2 ** D;
    localparam int ZERO_REG = 0;

    typedef enum logic [1:0] {
        DBG_IDLE = 2'd0,
        DBG_ACK  = 2'd1,
        DBG_WAIT = 2'd2
    } dbg_state_t;

    function automatic logic is_zero(input logic [D-1:0] addr);
        return addr == D'(ZERO_REG);
    endfunction

endpackage

// File: rtl/regbank_scoreboard.sv
// ----------------------------------------------------------------------------
// regbank_scoreboard
// Pending-write tracker for outstanding loads. A bit is set when decode issues
// a load to a register and cleared when write-back retires a write to it.
// stall flags a decode operand that still waits on such a load.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   issue_en     - decode issues a load to issue_addr
//   issue_addr   - load destination to mark pending
//   wb_en        - write-back RegWrite
//   wb_addr      - write-back destination (clears its pending bit)
//   rs_addr      - decode operand A address
//   rt_addr      - decode operand B address
//   stall        - an operand waits on a pending register
// ----------------------------------------------------------------------------
module regbank_scoreboard
    import regbank_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         issue_en,
    input  logic [D-1:0] issue_addr,
    input  logic         wb_en,
    input  logic [D-1:0] wb_addr,
    input  logic [D-1:0] rs_addr,
    input  logic [D-1:0] rt_addr,
    output logic         stall
);

    logic [NUM_REGS-1:0] pending;

    // The set is written after the clear so that a load issued to the same
    // register that is retiring this edge keeps the register pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            if (wb_en && !is_zero(wb_addr))
                pending[wb_addr] <= 1'b0;
            if (issue_en && !is_zero(issue_addr))
                pending[issue_addr] <= 1'b1;
        end
    end

    // A write-back landing this cycle resolves the hazard through the bypass.
    function automatic logic hazard(input logic [D-1:0] addr,
                                    input logic [NUM_REGS-1:0] pend,
                                    input logic w_en,
                                    input logic [D-1:0] w_addr);
        return !is_zero(addr) && pend[addr] && !(w_en && (w_addr == addr));
    endfunction

    always_comb begin
        stall = hazard(rs_addr, pending, wb_en, wb_addr) ||
                hazard(rt_addr, pending, wb_en, wb_addr);
    end

endmodule

// File: rtl/register_bank.sv
// ----------------------------------------------------------------------------
// register_bank
// MIPS general register file at the end of write-back: 2^D x B-bit registers,
// one write port, two combinational read ports with same-cycle write bypass,
// a pending-load scoreboard producing stall, and a handshaked debug read port.
//
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   rs_addr / rs_data   - decode operand A address / value
//   rt_addr / rt_data   - decode operand B address / value
//   wb_en, wb_addr,
//   wb_data             - write-back RegWrite, destination, data
//   issue_en,
//   issue_addr          - decode issues a load to issue_addr (marks pending)
//   stall               - operand hazard on a pending register
//   dbg_req, dbg_addr   - debug read request (level) and register address
//   dbg_ack             - one-cycle pulse: dbg_data is valid
//   dbg_data            - captured debug value, held until the next capture
// ----------------------------------------------------------------------------
module register_bank
    import regbank_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [D-1:0] rs_addr,
    input  logic [D-1:0] rt_addr,
    output logic [B-1:0] rs_data,
    output logic [B-1:0] rt_data,
    input  logic         wb_en,
    input  logic [D-1:0] wb_addr,
    input  logic [B-1:0] wb_data,
    input  logic         issue_en,
    input  logic [D-1:0] issue_addr,
    output logic         stall,
    input  logic         dbg_req,
    input  logic [D-1:0] dbg_addr,
    output logic         dbg_ack,
    output logic [B-1:0] dbg_data
);

    logic [B-1:0] regs [NUM_REGS];
    dbg_state_t   dbg_state_q;
    dbg_state_t   dbg_state_d;
    logic         dbg_capture;

    // Register array; entry 0 is never written so it stays at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wb_en && !is_zero(wb_addr)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Read ports: zero register first, then same-cycle bypass, then array.
    always_comb begin
        rs_data = regs[rs_addr];
        if (is_zero(rs_addr))
            rs_data = '0;
        else if (wb_en && (rs_addr == wb_addr))
            rs_data = wb_data;
    end

    always_comb begin
        rt_data = regs[rt_addr];
        if (is_zero(rt_addr))
            rt_data = '0;
        else if (wb_en && (rt_addr == wb_addr))
            rt_data = wb_data;
    end

    regbank_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .stall      (stall)
    );

    // Debug handshake state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dbg_state_q <= DBG_IDLE;
        else
            dbg_state_q <= dbg_state_d;
    end

    // dbg_ack is decoded from the state, so it drops as soon as reset forces
    // the FSM back to IDLE. WAIT holds off a new capture until the requester
    // has released dbg_req, giving exactly one pulse per request.
    always_comb begin
        dbg_state_d = dbg_state_q;
        dbg_ack     = 1'b0;
        dbg_capture = 1'b0;
        case (dbg_state_q)
            DBG_IDLE: begin
                if (dbg_req) begin
                    dbg_capture = 1'b1;
                    dbg_state_d = DBG_ACK;
                end
            end
            DBG_ACK: begin
                dbg_ack     = 1'b1;
                dbg_state_d = DBG_WAIT;
            end
            DBG_WAIT: begin
                if (!dbg_req)
                    dbg_state_d = DBG_IDLE;
            end
            default: begin
                dbg_state_d = DBG_IDLE;
            end
        endcase
    end

    // Capture reads the array as it stood before this edge's write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dbg_data <= '0;
        else if (dbg_capture)
            dbg_data <= regs[dbg_addr];
    end

endmodule

// File: tb/tb_register_bank.sv
module tb_register_bank;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        stall;
    logic        dbg_req;
    logic [4:0]  dbg_addr;
    logic        dbg_ack;
    logic [31:0] dbg_data;

    int n_pass  = 0;
    int n_total = 0;

    register_bank dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .stall      (stall),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_ack    (dbg_ack),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        issue_en;
        logic [4:0]  issue_addr;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
        logic        exp_stall;
    } vec_t;

    typedef struct packed {
        logic [31:0] rs;
        logic [31:0] rt;
        logic        stall;
    } exp_t;

    localparam int NVEC = 20;
    vec_t        vec [NVEC];
    exp_t        sb_q [$];
    logic [31:0] dbg_q [$];

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic ie, input logic [4:0] ia,
                                input logic [4:0] ra, input logic [4:0] ta,
                                input logic [31:0] er, input logic [31:0] et, input logic es);
        vec_t v;
        v.wb_en = we; v.wb_addr = wa; v.wb_data = wd;
        v.issue_en = ie; v.issue_addr = ia;
        v.rs_addr = ra; v.rt_addr = ta;
        v.exp_rs = er; v.exp_rt = et; v.exp_stall = es;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic quiet();
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        issue_en = 1'b0; issue_addr = '0;
    endtask

    initial begin
        exp_t        e;
        logic [31:0] d;

        rst_n = 1'b0;
        rs_addr = '0; rt_addr = '0;
        dbg_req = 1'b0; dbg_addr = '0;
        quiet();

        // Vectors: applied one per cycle, expected values hand-derived.
        vec[0]  = mk(1,  5, 32'hDEADBEEF, 0, 0,  5,  5, 32'hDEADBEEF, 32'hDEADBEEF, 0);
        vec[1]  = mk(0,  0, 32'h0,        0, 0,  5,  5, 32'hDEADBEEF, 32'hDEADBEEF, 0);
        vec[2]  = mk(1,  0, 32'h12345678, 0, 0,  0,  0, 32'h0,        32'h0,        0);
        vec[3]  = mk(0,  0, 32'h0,        0, 0,  0,  5, 32'h0,        32'hDEADBEEF, 0);
        vec[4]  = mk(0,  0, 32'h0,        1, 7,  7,  0, 32'h0,        32'h0,        0);
        vec[5]  = mk(0,  0, 32'h0,        0, 0,  7,  0, 32'h0,        32'h0,        1);
        vec[6]  = mk(0,  0, 32'h0,        0, 0,  7,  5, 32'h0,        32'hDEADBEEF, 1);
        vec[7]  = mk(1,  7, 32'h55,       0, 0,  7,  0, 32'h55,       32'h0,        0);
        vec[8]  = mk(0,  0, 32'h0,        0, 0,  7,  7, 32'h55,       32'h55,       0);
        vec[9]  = mk(1,  9, 32'hA5,       1, 9,  0,  9, 32'h0,        32'hA5,       0);
        vec[10] = mk(0,  0, 32'h0,        0, 0,  0,  9, 32'h0,        32'hA5,       1);
        vec[11] = mk(1, 12, 32'h1,        0, 0, 12,  9, 32'h1,        32'hA5,       1);
        vec[12] = mk(1,  9, 32'h77,       0, 0,  0,  9, 32'h0,        32'h77,       0);
        vec[13] = mk(0,  0, 32'h0,        0, 0,  0,  9, 32'h0,        32'h77,       0);
        vec[14] = mk(0,  0, 32'h0,        1, 0,  0,  0, 32'h0,        32'h0,        0);
        vec[15] = mk(0,  0, 32'h0,        0, 0,  0,  0, 32'h0,        32'h0,        0);
        vec[16] = mk(0,  0, 32'h0,        1, 3,  5,  0, 32'hDEADBEEF, 32'h0,        0);
        vec[17] = mk(0,  0, 32'h0,        0, 0,  0,  3, 32'h0,        32'h0,        1);
        vec[18] = mk(1,  3, 32'h33,       0, 0,  3,  3, 32'h33,       32'h33,       0);
        vec[19] = mk(0, 12, 32'h99,       0, 0, 12,  0, 32'h1,        32'h0,        0);

        // Reset state, while asserted and after release across all addresses.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rs_addr = 5'd5; rt_addr = 5'd31;
        #1;
        chk("rst_asserted_rs", rs_data, 32'h0);
        chk("rst_asserted_stall", {31'b0, stall}, 32'h0);
        chk("rst_dbg_data", dbg_data, 32'h0);
        chk("rst_dbg_ack", {31'b0, dbg_ack}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            @(negedge clk);
            chk($sformatf("scan_rs_r%0d", i), rs_data, 32'h0);
            chk($sformatf("scan_rt_r%0d", 31 - i), rt_data, 32'h0);
            chk($sformatf("scan_stall_%0d", i), {31'b0, stall}, 32'h0);
            chk($sformatf("scan_ack_%0d", i), {31'b0, dbg_ack}, 32'h0);
        end

        // Table-driven write/bypass/scoreboard vectors.
        for (int v = 0; v < NVEC; v++) begin
            @(posedge clk);
            #1;
            wb_en = vec[v].wb_en; wb_addr = vec[v].wb_addr; wb_data = vec[v].wb_data;
            issue_en = vec[v].issue_en; issue_addr = vec[v].issue_addr;
            rs_addr = vec[v].rs_addr; rt_addr = vec[v].rt_addr;
            sb_q.push_back('{rs: vec[v].exp_rs, rt: vec[v].exp_rt, stall: vec[v].exp_stall});
            @(negedge clk);
            if (sb_q.size() == 0) begin
                chk("sb_queue_empty", 32'h0, 32'h1);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("vec%0d_rs", v), rs_data, e.rs);
                chk($sformatf("vec%0d_rt", v), rt_data, e.rt);
                chk($sformatf("vec%0d_stall", v), {31'b0, stall}, {31'b0, e.stall});
            end
        end
        @(posedge clk);
        #1;
        quiet();
        rs_addr = '0; rt_addr = '0;

        // Debug read of r5 with dbg_req held four cycles: one ack, cycle after.
        dbg_addr = 5'd5;
        dbg_req = 1'b1;
        dbg_q.push_back(32'hDEADBEEF);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk($sformatf("dbg1_ack_c%0d", c), {31'b0, dbg_ack}, {31'b0, (c == 1)});
            if (dbg_ack) begin
                if (dbg_q.size() == 0) begin
                    chk("dbg_queue_empty", 32'h0, 32'h1);
                end else begin
                    d = dbg_q.pop_front();
                    chk("dbg1_data", dbg_data, d);
                end
            end
            @(posedge clk);
            #1;
            if (c == 3) dbg_req = 1'b0;
        end
        chk("dbg1_hold", dbg_data, 32'hDEADBEEF);

        // Capture sees the array before a same-edge write to that register.
        dbg_addr = 5'd12;
        dbg_req = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'h99;
        dbg_q.push_back(32'h1);
        @(negedge clk);
        chk("dbg2_ack_pre", {31'b0, dbg_ack}, 32'h0);
        @(posedge clk);
        #1;
        quiet();
        dbg_req = 1'b0;
        rs_addr = 5'd12;
        @(negedge clk);
        chk("dbg2_ack", {31'b0, dbg_ack}, 32'h1);
        if (dbg_q.size() == 0) begin
            chk("dbg_queue_empty", 32'h0, 32'h1);
        end else begin
            d = dbg_q.pop_front();
            chk("dbg2_data", dbg_data, d);
        end
        chk("r12_after_write", rs_data, 32'h99);
        repeat (2) begin
            @(negedge clk);
            chk("dbg2_ack_after", {31'b0, dbg_ack}, 32'h0);
        end

        // Reset in the ACK state with r7 pending.
        @(posedge clk);
        #1;
        issue_en = 1'b1; issue_addr = 5'd7;
        dbg_addr = 5'd5; dbg_req = 1'b1;
        rs_addr = 5'd7;
        @(posedge clk);
        #1;
        quiet();
        @(negedge clk);
        chk("mid_ack_before_rst", {31'b0, dbg_ack}, 32'h1);
        chk("mid_stall_before_rst", {31'b0, stall}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_ack_in_rst", {31'b0, dbg_ack}, 32'h0);
        chk("mid_stall_in_rst", {31'b0, stall}, 32'h0);
        chk("mid_dbg_data_in_rst", dbg_data, 32'h0);
        @(posedge clk);
        #1;
        dbg_req = 1'b0;
        rst_n = 1'b1;
        rt_addr = 5'd5;
        @(negedge clk);
        chk("post_rst_stall_r7", {31'b0, stall}, 32'h0);
        chk("post_rst_r7", rs_data, 32'h0);
        chk("post_rst_r5", rt_data, 32'h0);
        chk("post_rst_ack", {31'b0, dbg_ack}, 32'h0);
        @(negedge clk);
        chk("post_rst_stall_r7_2", {31'b0, stall}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
